// File: rtl/ram_dp_dist_param.sv
// -----------------------------------------------------------------------------
// ram_dp_dist_param
//
// Parametrised dual-port distributed RAM, 2**ADDR_W words x WIDTH bits.
// One synchronous write port (A/D/WE) and two asynchronous read ports:
// SPO reads mem[A], DPO reads mem[DPRA].
//
// After reset a clear sequencer walks every address and writes INIT_WORD,
// holding BUSY high until the last word is written. User writes are ignored
// and both read ports return zero while BUSY is high. A write whose address
// matches DPRA raises COLL for one cycle.
//
// Parameters
//   WIDTH      data width in bits (>=1)
//   ADDR_W     address width, DEPTH = 2**ADDR_W (1..10)
//   INIT_WORD  value loaded into every word by the clear sequencer
//   WCLK_INV   0: state updates on rising WCLK, 1: on falling WCLK
//
// Ports
//   WCLK   in   1       write / sequencer clock
//   RST_N  in   1       asynchronous active-low reset
//   WE     in   1       write enable (ignored while clearing)
//   A      in   ADDR_W  write address and SPO read address
//   D      in   WIDTH   write data
//   DPRA   in   ADDR_W  DPO read address
//   SPO    out  WIDTH   mem[A]   (0 while BUSY)
//   DPO    out  WIDTH   mem[DPRA](0 while BUSY)
//   BUSY   out  1       clear sequencer running
//   COLL   out  1       one-cycle pulse after a write with A == DPRA
//
// Build option
//   RAM_DP_OREG_EN  when defined, SPO/DPO are registered (one cycle read
//                   latency) and COLL is delayed one extra cycle so it stays
//                   aligned with the registered DPO.
// -----------------------------------------------------------------------------
module ram_dp_dist_param #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       ADDR_W    = 5,
  parameter logic [WIDTH-1:0]  INIT_WORD = {WIDTH{1'b0}},
  parameter int unsigned       WCLK_INV  = 0
) (
  input  logic              WCLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] DPRA,
  output logic [WIDTH-1:0]  SPO,
  output logic [WIDTH-1:0]  DPO,
  output logic              BUSY,
  output logic              COLL
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Active clock: every flop and the array use clk_act, so WCLK_INV moves the
  // whole block onto the falling edge of WCLK in one place.
  // ---------------------------------------------------------------------------
  logic clk_act;

  generate
    if (WCLK_INV != 0) begin : g_clk_neg
      assign clk_act = ~WCLK;
    end else begin : g_clk_pos
      assign clk_act = WCLK;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic              coll_q,  coll_d;

  // Array write port, shared by the clear sequencer and the user port
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic              busy;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    coll_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = A;
    mem_wdata = D;

    case (state_q)
      ST_CLEAR: begin
        // Sequencer owns the write port; WE is ignored.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = INIT_WORD;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          // Last word written: ptr holds here, it never wraps in READY.
          state_d = ST_READY;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end

      ST_READY: begin
        // An unknown WE falls to the else path in simulation, so an X/Z
        // enable is treated as no write and raises no collision.
        if (WE) begin
          mem_we = 1'b1;
          coll_d = (A == DPRA);
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk_act or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coll_q  <= coll_d;
    end
  end

  assign busy = (state_q == ST_CLEAR);
  assign BUSY = busy;

  // ---------------------------------------------------------------------------
  // Storage array
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch; a reset on a memory would stop it
  // mapping onto distributed RAM. The clear sequencer initialises it instead.
  always_ff @(posedge clk_act) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Asynchronous read of both ports; a write is visible right after its edge.
  logic [WIDTH-1:0] spo_raw;
  logic [WIDTH-1:0] dpo_raw;

  assign spo_raw = mem_q[A];
  assign dpo_raw = mem_q[DPRA];

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef RAM_DP_OREG_EN
  logic [WIDTH-1:0] spo_q, spo_d;
  logic [WIDTH-1:0] dpo_q, dpo_d;
  logic             coll_dly_q, coll_dly_d;

  always_comb begin
    spo_d      = busy ? '0 : spo_raw;
    dpo_d      = busy ? '0 : dpo_raw;
    // The registered DPO shows a write one edge later than the array does,
    // so COLL is pushed back by the same amount.
    coll_dly_d = coll_q;
  end

  always_ff @(posedge clk_act or negedge RST_N) begin
    if (!RST_N) begin
      spo_q      <= '0;
      dpo_q      <= '0;
      coll_dly_q <= 1'b0;
    end else begin
      spo_q      <= spo_d;
      dpo_q      <= dpo_d;
      coll_dly_q <= coll_dly_d;
    end
  end

  assign SPO  = spo_q;
  assign DPO  = dpo_q;
  assign COLL = coll_dly_q;
`else
  assign SPO  = busy ? '0 : spo_raw;
  assign DPO  = busy ? '0 : dpo_raw;
  assign COLL = coll_q;
`endif

endmodule

// File: tb/tb_ram_dp_dist_param.sv
// -----------------------------------------------------------------------------
// tb_ram_dp_dist_param
//
// Bench for ram_dp_dist_param (default build, asynchronous reads).
// Two instances share all inputs: u_pos (WCLK_INV=0) and u_neg (WCLK_INV=1),
// both WIDTH=8, ADDR_W=5, INIT_WORD=8'hA5.
//
// Stimulus is driven 1 time unit after each rising WCLK. Expected values are
// pushed into one queue per instance; a monitor per instance drains its queue
// on the edge opposite to that instance's active edge (falling WCLK for
// u_pos, rising WCLK for u_neg) and compares.
// -----------------------------------------------------------------------------
module tb_ram_dp_dist_param;

  localparam int S_SPO  = 0;
  localparam int S_DPO  = 1;
  localparam int S_BUSY = 2;
  localparam int S_COLL = 3;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t q_pos[$];
  exp_t q_neg[$];

  int checks   = 0;
  int failures = 0;

  logic       wclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       we    = 1'b0;
  logic [4:0] a     = '0;
  logic [7:0] d     = '0;
  logic [4:0] dpra  = '0;

  logic [7:0] spo_p, dpo_p, spo_n, dpo_n;
  logic       busy_p, coll_p, busy_n, coll_n;

  always #5 wclk = ~wclk;

  ram_dp_dist_param #(
    .WIDTH(8), .ADDR_W(5), .INIT_WORD(8'hA5), .WCLK_INV(0)
  ) u_pos (
    .WCLK(wclk), .RST_N(rst_n), .WE(we), .A(a), .D(d), .DPRA(dpra),
    .SPO(spo_p), .DPO(dpo_p), .BUSY(busy_p), .COLL(coll_p)
  );

  ram_dp_dist_param #(
    .WIDTH(8), .ADDR_W(5), .INIT_WORD(8'hA5), .WCLK_INV(1)
  ) u_neg (
    .WCLK(wclk), .RST_N(rst_n), .WE(we), .A(a), .D(d), .DPRA(dpra),
    .SPO(spo_n), .DPO(dpo_n), .BUSY(busy_n), .COLL(coll_n)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_pos(input string name, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q_pos.push_back(e);
  endtask

  task automatic exp_neg(input string name, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q_neg.push_back(e);
  endtask

  function automatic logic [7:0] pick_pos(input int sel);
    case (sel)
      S_SPO:   return spo_p;
      S_DPO:   return dpo_p;
      S_BUSY:  return {7'd0, busy_p};
      default: return {7'd0, coll_p};
    endcase
  endfunction

  function automatic logic [7:0] pick_neg(input int sel);
    case (sel)
      S_SPO:   return spo_n;
      S_DPO:   return dpo_n;
      S_BUSY:  return {7'd0, busy_n};
      default: return {7'd0, coll_n};
    endcase
  endfunction

  // Monitors
  always @(negedge wclk) begin
    while (q_pos.size() > 0) begin
      exp_t e;
      e = q_pos.pop_front();
      check({"pos_", e.name}, pick_pos(e.sel), e.exp);
    end
  end

  always @(posedge wclk) begin
    while (q_neg.size() > 0) begin
      exp_t e;
      e = q_neg.pop_front();
      check({"neg_", e.name}, pick_neg(e.sel), e.exp);
    end
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  // Runs the clear window that starts with RST_N rising (caller releases it
  // just after a rising edge). At step k, u_pos has seen k active edges when
  // sampled and u_neg has seen k+1, so each BUSY must fall on edge 32.
  // WE is held at its current value until step 31 so a pending write is
  // offered to the array throughout the clear.
  task automatic run_clear(input string tag);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 31) we = 1'b0;
      exp_pos($sformatf("%s_busy_e%0d", tag, k), S_BUSY, (k < 32) ? 8'd1 : 8'd0);
      if (k <= 31)
        exp_neg($sformatf("%s_busy_e%0d", tag, k + 1), S_BUSY,
                (k + 1 < 32) ? 8'd1 : 8'd0);
      if (k == 10) begin
        exp_pos({tag, "_spo_busy0"}, S_SPO, 8'h00);
        exp_pos({tag, "_dpo_busy0"}, S_DPO, 8'h00);
        exp_neg({tag, "_spo_busy0"}, S_SPO, 8'h00);
        exp_neg({tag, "_dpo_busy0"}, S_DPO, 8'h00);
      end
    end
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    exp_pos("rst_busy", S_BUSY, 8'd1);
    exp_pos("rst_coll", S_COLL, 8'd0);
    exp_pos("rst_spo",  S_SPO,  8'h00);
    exp_pos("rst_dpo",  S_DPO,  8'h00);
    exp_neg("rst_busy", S_BUSY, 8'd1);
    exp_neg("rst_coll", S_COLL, 8'd0);
    repeat (3) step();

    // Release with a write attempt pending during the whole clear
    rst_n = 1'b1;
    we = 1'b1; a = 5'd3; d = 8'h11; dpra = 5'd3;
    run_clear("clr1");

    // Full sweep: every word holds INIT_WORD, including address 3
    for (int i = 0; i < 32; i++) begin
      step();
      a = 5'(i); dpra = 5'(i);
      exp_pos($sformatf("sweep_dpo%0d", i), S_DPO, 8'hA5);
      exp_pos($sformatf("sweep_spo%0d", i), S_SPO, 8'hA5);
      exp_neg($sformatf("sweep_dpo%0d", i), S_DPO, 8'hA5);
    end

    // Write then read at address 7
    step();
    we = 1'b1; a = 5'd7; d = 8'h3C; dpra = 5'd0;
    exp_pos("wr7_before_edge", S_SPO, 8'hA5);
    exp_neg("wr7_after_fall",  S_SPO, 8'h3C);
    step();
    we = 1'b0; dpra = 5'd7;
    exp_pos("rd7_dpo", S_DPO, 8'h3C);
    exp_pos("rd7_spo", S_SPO, 8'h3C);
    exp_neg("rd7_dpo", S_DPO, 8'h3C);
    step();
    dpra = 5'd8;
    exp_pos("rd8_dpo", S_DPO, 8'hA5);
    exp_neg("rd8_dpo", S_DPO, 8'hA5);

    // Collision at address 12
    step();
    we = 1'b1; a = 5'd12; dpra = 5'd12; d = 8'hF0;
    exp_pos("coll_pre",     S_COLL, 8'd0);
    exp_pos("coll_pre_dpo", S_DPO,  8'hA5);
    exp_neg("coll_pulse",   S_COLL, 8'd1);
    exp_neg("coll_dpo",     S_DPO,  8'hF0);
    step();
    we = 1'b0;
    exp_pos("coll_pulse", S_COLL, 8'd1);
    exp_pos("coll_dpo",   S_DPO,  8'hF0);
    exp_neg("coll_end",   S_COLL, 8'd0);
    step();
    exp_pos("coll_end", S_COLL, 8'd0);

    // Same write with a different DPRA: no collision
    step();
    we = 1'b1; a = 5'd12; dpra = 5'd13; d = 8'h0F;
    exp_pos("nocoll_a", S_COLL, 8'd0);
    exp_neg("nocoll_a", S_COLL, 8'd0);
    exp_neg("nocoll_spo", S_SPO, 8'h0F);
    step();
    we = 1'b0;
    exp_pos("nocoll_b",   S_COLL, 8'd0);
    exp_pos("nocoll_spo", S_SPO,  8'h0F);
    exp_pos("nocoll_dpo", S_DPO,  8'hA5);

    // WE high only between the falling and the next rising edge:
    // only the falling-edge instance may take the write.
    step();
    we = 1'b1; a = 5'd20; dpra = 5'd20; d = 8'h55;
    exp_neg("fall_wr_dpo",  S_DPO,  8'h55);
    exp_neg("fall_wr_coll", S_COLL, 8'd1);
    @(negedge wclk);
    #1;
    we = 1'b0;
    step();
    exp_pos("rise_nowr_dpo",  S_DPO,  8'hA5);
    exp_pos("rise_nowr_coll", S_COLL, 8'd0);
    exp_neg("fall_wr_hold",   S_DPO,  8'h55);

    // Reset from READY takes effect at once (sampled before any rising edge)
    step();
    a = 5'd12; dpra = 5'd13;
    rst_n = 1'b0;
    exp_pos("rst2_busy", S_BUSY, 8'd1);
    exp_pos("rst2_spo",  S_SPO,  8'h00);
    exp_pos("rst2_dpo",  S_DPO,  8'h00);
    exp_neg("rst2_busy", S_BUSY, 8'd1);
    exp_neg("rst2_spo",  S_SPO,  8'h00);
    step();
    rst_n = 1'b1;

    // Let the clear run 10 edges, then reset mid-clear
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_pos($sformatf("part_busy_e%0d", k), S_BUSY, 8'd1);
    end
    rst_n = 1'b0;
    exp_pos("rst3_busy", S_BUSY, 8'd1);
    exp_pos("rst3_spo",  S_SPO,  8'h00);
    exp_neg("rst3_busy", S_BUSY, 8'd1);
    step();
    rst_n = 1'b1;
    run_clear("clr2");

    // The restarted clear overwrote the earlier user data
    step();
    dpra = 5'd7; a = 5'd12;
    exp_pos("post_clr_dpo7",  S_DPO, 8'hA5);
    exp_pos("post_clr_spo12", S_SPO, 8'hA5);
    exp_neg("post_clr_dpo7",  S_DPO, 8'hA5);
    step();
    dpra = 5'd20;
    exp_neg("post_clr_dpo20", S_DPO, 8'hA5);

    // Drain and confirm every expectation was consumed
    repeat (3) step();
    checks++;
    if (q_pos.size() != 0 || q_neg.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending entries expected 0/0",
               q_pos.size(), q_neg.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
